// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer pointer/occupancy sequencer: allocates tail slots, retires the
// head in order (one per cycle), handshakes store retirement and drives the regfile bus.
module rob_commit_ctrl #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_req,
    output logic             issue_ack,
    output logic [IDX_W-1:0] issue_rob_idx,
    input  logic             head_done,
    input  logic             head_is_store,
    input  logic [4:0]       head_dr,
    input  logic [31:0]      head_value,
    output logic             st_commit_req,
    input  logic             st_commit_ack,
    input  logic             flush,
    output logic             commit,
    output logic [IDX_W-1:0] commit_ptr_rob_idx,
    output logic             commit_ready,
    output logic             cir_q_empty,
    output logic             cir_q_full,
    output logic [IDX_W:0]   occupancy,
    output logic             rf_valid,
    output logic [31:0]      rf_value,
    output logic [IDX_W-1:0] rf_rob_idx,
    output logic [4:0]       rf_regfile_idx
);

    localparam logic [0:0]       RUN        = 1'b0;
    localparam logic [0:0]       ST_WAIT    = 1'b1;
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] PTR_STEP   = IDX_W'(1);

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             kill;

    assign kill               = flush | rst;
    assign issue_rob_idx      = tail;
    assign commit_ptr_rob_idx = head;
    assign occupancy          = count;

    always_comb begin
        cir_q_empty   = (count == '0);
        cir_q_full    = (count == FULL_COUNT);
        // Full is judged on the registered count only, so a same-cycle commit never frees a slot.
        issue_ack     = issue_req & ~cir_q_full & ~kill;
        commit_ready  = (state == RUN) & ~cir_q_empty & head_done;
        commit        = 1'b0;
        st_commit_req = 1'b0;
        state_nxt     = state;
        case (state)
            RUN: begin
                if (commit_ready) begin
                    if (head_is_store) begin
                        st_commit_req = 1'b1;
                        if (st_commit_ack) begin
                            commit = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // head_done is not consulted here; the store was already found done.
                st_commit_req = ~cir_q_empty;
                if (st_commit_ack & ~cir_q_empty) begin
                    commit    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (kill) begin
            commit        = 1'b0;
            st_commit_req = 1'b0;
            state_nxt     = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            state          <= RUN;
            rf_valid       <= 1'b0;
            rf_value       <= '0;
            rf_rob_idx     <= '0;
            rf_regfile_idx <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= RUN;
            rf_valid <= 1'b0;
        end else begin
            if (issue_ack) begin
                tail <= tail + PTR_STEP;
            end
            if (commit) begin
                head <= head + PTR_STEP;
            end
            count    <= count + (IDX_W+1)'(issue_ack) - (IDX_W+1)'(commit);
            state    <= state_nxt;
            rf_valid <= commit & (head_dr != 5'd0) & ~head_is_store;
            if (commit) begin
                rf_value       <= head_value;
                rf_rob_idx     <= head;
                rf_regfile_idx <= head_dr;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= FULL_COUNT)
                else $error("rob_commit_ctrl: count exceeds DEPTH");
            assert (cir_q_empty == (count == '0))
                else $error("rob_commit_ctrl: empty flag inconsistent");
            assert (cir_q_full == (count == FULL_COUNT))
                else $error("rob_commit_ctrl: full flag inconsistent");
            assert (!(commit && cir_q_empty))
                else $error("rob_commit_ctrl: commit while empty");
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: queue-based occupancy model, directed
// scenarios with literal expectations, then a randomized phase.
module tb_rob_commit_ctrl;

    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_req;
    logic             issue_ack;
    logic [IDX_W-1:0] issue_rob_idx;
    logic             head_done;
    logic             head_is_store;
    logic [4:0]       head_dr;
    logic [31:0]      head_value;
    logic             st_commit_req;
    logic             st_commit_ack;
    logic             flush;
    logic             commit;
    logic [IDX_W-1:0] commit_ptr_rob_idx;
    logic             commit_ready;
    logic             cir_q_empty;
    logic             cir_q_full;
    logic [IDX_W:0]   occupancy;
    logic             rf_valid;
    logic [31:0]      rf_value;
    logic [IDX_W-1:0] rf_rob_idx;
    logic [4:0]       rf_regfile_idx;

    always #5 clk = ~clk;

    rob_commit_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .issue_req(issue_req), .issue_ack(issue_ack), .issue_rob_idx(issue_rob_idx),
        .head_done(head_done), .head_is_store(head_is_store), .head_dr(head_dr),
        .head_value(head_value), .st_commit_req(st_commit_req), .st_commit_ack(st_commit_ack),
        .flush(flush), .commit(commit), .commit_ptr_rob_idx(commit_ptr_rob_idx),
        .commit_ready(commit_ready), .cir_q_empty(cir_q_empty), .cir_q_full(cir_q_full),
        .occupancy(occupancy), .rf_valid(rf_valid), .rf_value(rf_value),
        .rf_rob_idx(rf_rob_idx), .rf_regfile_idx(rf_regfile_idx)
    );

    int checks = 0;
    int errors = 0;

    // Model: list of live ROB indices (oldest first), next index to allocate,
    // and whether a store is waiting for the memory ack.
    int          live[$];
    int          next_idx = 0;
    bit          pending = 0;
    bit          m_rf_valid = 0;
    logic [31:0] m_rf_value = '0;
    int          m_rf_rob = 0;
    int          m_rf_dr = 0;
    bit          e_ack, e_commit, e_streq, e_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_head();
        return (live.size() != 0) ? live[0] : next_idx;
    endfunction

    task automatic compare_all();
        bit empty, full, kill;
        empty    = (live.size() == 0);
        full     = (live.size() == DEPTH);
        kill     = flush | rst;
        e_ack    = issue_req & !full & !kill;
        e_ready  = !pending & !empty & head_done;
        e_commit = 1'b0;
        e_streq  = 1'b0;
        if (!kill && !empty) begin
            if (pending) begin
                e_streq  = 1'b1;
                e_commit = st_commit_ack;
            end else if (e_ready) begin
                e_streq  = head_is_store;
                e_commit = !head_is_store | st_commit_ack;
            end
        end
        chk("issue_ack", 32'(issue_ack), 32'(e_ack));
        chk("issue_rob_idx", 32'(issue_rob_idx), next_idx);
        chk("commit", 32'(commit), 32'(e_commit));
        chk("commit_ptr", 32'(commit_ptr_rob_idx), model_head());
        chk("commit_ready", 32'(commit_ready), 32'(e_ready));
        chk("st_commit_req", 32'(st_commit_req), 32'(e_streq));
        chk("empty", 32'(cir_q_empty), 32'(empty));
        chk("full", 32'(cir_q_full), 32'(full));
        chk("occupancy", 32'(occupancy), live.size());
        chk("rf_valid", 32'(rf_valid), 32'(m_rf_valid));
        chk("rf_value", rf_value, m_rf_value);
        chk("rf_rob_idx", 32'(rf_rob_idx), m_rf_rob);
        chk("rf_regfile_idx", 32'(rf_regfile_idx), m_rf_dr);
        chk("inv_empty_occ", 32'(cir_q_empty), 32'(occupancy == 0));
        chk("inv_commit_empty", 32'(commit & cir_q_empty), 32'd0);
    endtask

    task automatic model_update();
        if (rst) begin
            live.delete();
            next_idx   = 0;
            pending    = 0;
            m_rf_valid = 0;
            m_rf_value = '0;
            m_rf_rob   = 0;
            m_rf_dr    = 0;
        end else if (flush) begin
            live.delete();
            next_idx   = 0;
            pending    = 0;
            m_rf_valid = 0;
        end else begin
            if (e_commit) begin
                m_rf_valid = (head_dr != 0) && !head_is_store;
                m_rf_value = head_value;
                m_rf_rob   = live.pop_front();
                m_rf_dr    = int'(head_dr);
                pending    = 0;
            end else begin
                m_rf_valid = 0;
                if (e_streq) pending = 1;
            end
            if (e_ack) begin
                live.push_back(next_idx);
                next_idx = (next_idx + 1) % DEPTH;
            end
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        issue_req = 0; head_done = 0; head_is_store = 0; head_dr = 0;
        head_value = 0; st_commit_ack = 0; flush = 0; rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        settle();
        chk("reset_empty", 32'(cir_q_empty), 32'd1);
        chk("reset_rf_valid", 32'(rf_valid), 32'd0);
        advance();
        rst = 0;

        // 1: fill to full, 33rd request refused
        issue_req = 1;
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            chk("t1_idx", 32'(issue_rob_idx), i);
            chk("t1_ack", 32'(issue_ack), 32'd1);
            advance();
        end
        settle();
        chk("t1_full", 32'(cir_q_full), 32'd1);
        chk("t1_occ", 32'(occupancy), 32'd32);
        chk("t1_ack33", 32'(issue_ack), 32'd0);
        advance();
        issue_req = 0; flush = 1;
        cyc();
        flush = 0;

        // 2: three back-to-back ALU commits
        issue_req = 1;
        repeat (3) cyc();
        issue_req = 0; head_done = 1; head_dr = 5; head_value = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t2_commit", 32'(commit), 32'd1);
            chk("t2_ptr", 32'(commit_ptr_rob_idx), k);
            if (k > 0) begin
                chk("t2_rf_valid", 32'(rf_valid), 32'd1);
                chk("t2_rf_rob", 32'(rf_rob_idx), k - 1);
            end
            advance();
        end
        settle();
        chk("t2_rf_valid_last", 32'(rf_valid), 32'd1);
        chk("t2_rf_rob_last", 32'(rf_rob_idx), 32'd2);
        chk("t2_rf_value", rf_value, 32'hDEADBEEF);
        chk("t2_rf_dr", 32'(rf_regfile_idx), 32'd5);
        chk("t2_empty", 32'(cir_q_empty), 32'd1);
        advance();

        // 3: store with ack four cycles late
        head_done = 0; issue_req = 1;
        cyc();
        issue_req = 0; head_done = 1; head_is_store = 1; head_dr = 7;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t3_streq", 32'(st_commit_req), 32'd1);
            chk("t3_nocommit", 32'(commit), 32'd0);
            advance();
        end
        st_commit_ack = 1;
        settle();
        chk("t3_streq_ack", 32'(st_commit_req), 32'd1);
        chk("t3_commit", 32'(commit), 32'd1);
        advance();
        st_commit_ack = 0; head_is_store = 0; head_done = 0;
        settle();
        chk("t3_rf_valid", 32'(rf_valid), 32'd0);
        chk("t3_empty", 32'(cir_q_empty), 32'd1);
        advance();

        // 4: move pointers to 30, then wrap with overlapped issue/commit
        issue_req = 1;
        repeat (26) cyc();
        issue_req = 0; head_done = 1; head_dr = 3;
        repeat (26) cyc();
        head_done = 0; issue_req = 1;
        settle();
        chk("t4_head30", 32'(commit_ptr_rob_idx), 32'd30);
        chk("t4_tail30", 32'(issue_rob_idx), 32'd30);
        advance();
        head_done = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t4_tail_seq", 32'(issue_rob_idx), (31 + k) % 32);
            chk("t4_occ_const", 32'(occupancy), 32'd1);
            chk("t4_commit", 32'(commit), 32'd1);
            advance();
        end
        issue_req = 0;
        cyc();
        head_done = 0;
        settle();
        chk("t4_head2", 32'(commit_ptr_rob_idx), 32'd2);
        chk("t4_occ0", 32'(occupancy), 32'd0);
        advance();

        // 5: flush while waiting on a store, occupancy 12
        issue_req = 1;
        repeat (12) cyc();
        issue_req = 0; head_done = 1; head_is_store = 1;
        repeat (2) cyc();
        flush = 1; issue_req = 1;
        settle();
        chk("t5_occ12", 32'(occupancy), 32'd12);
        chk("t5_flush_ack", 32'(issue_ack), 32'd0);
        chk("t5_flush_streq", 32'(st_commit_req), 32'd0);
        chk("t5_flush_commit", 32'(commit), 32'd0);
        advance();
        flush = 0; issue_req = 0;
        settle();
        chk("t5_ptr0", 32'(commit_ptr_rob_idx), 32'd0);
        chk("t5_tail0", 32'(issue_rob_idx), 32'd0);
        chk("t5_occ0", 32'(occupancy), 32'd0);
        chk("t5_streq0", 32'(st_commit_req), 32'd0);
        advance();
        head_is_store = 0; head_done = 0;

        // 6: x0 destination, then reset with occupancy 7
        issue_req = 1;
        repeat (2) cyc();
        issue_req = 0; head_done = 1; head_dr = 0; head_value = 32'h1234;
        settle();
        chk("t6_commit_x0", 32'(commit), 32'd1);
        advance();
        head_dr = 9; head_value = 32'h5678;
        settle();
        chk("t6_rf_valid_x0", 32'(rf_valid), 32'd0);
        advance();
        head_done = 0; issue_req = 1;
        settle();
        chk("t6_rf_rob1", 32'(rf_rob_idx), 32'd1);
        advance();
        repeat (6) cyc();
        issue_req = 0; rst = 1;
        settle();
        chk("t6_occ7", 32'(occupancy), 32'd7);
        advance();
        rst = 0;
        settle();
        chk("t6_rst_empty", 32'(cir_q_empty), 32'd1);
        chk("t6_rst_rf_value", rf_value, 32'd0);
        chk("t6_rst_rf_rob", 32'(rf_rob_idx), 32'd0);
        chk("t6_rst_rf_dr", 32'(rf_regfile_idx), 32'd0);
        advance();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            flush         = ($urandom_range(0, 59) == 0);
            issue_req     = ($urandom_range(0, 9) < 6);
            head_done     = ($urandom_range(0, 1) == 1);
            head_is_store = pending ? 1'b1 : ($urandom_range(0, 3) == 0);
            head_dr       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            head_value    = $urandom;
            st_commit_ack = ($urandom_range(0, 9) < 3);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Pointer, occupancy and retirement sequencer for the 32-entry reorder-buffer circular queues (destination-register, done, value and store arrays).
- Allocates tail slots on dispatch and retires the head entry in order, at most one per cycle.
- Handshakes store retirement with the memory side.
- Drives the commit/issue strobes, the empty/full flags and the registered writeback bus to the regfile (valid, value[31:0], rob_idx[4:0], regfile_idx[4:0]).

Parameters:
- DEPTH, 32, number of ROB entries (power of two)
- IDX_W, 5, log2(DEPTH), width of ROB indices

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- issue_req  in  1  dispatch requests a new ROB slot
- issue_ack  out  1  slot granted this cycle (issue strobe to the ROB arrays)
- issue_rob_idx  out  IDX_W  tail index granted
- head_done  in  1  done bit of the entry at commit_ptr_rob_idx
- head_is_store  in  1  store bit of the head entry
- head_dr  in  5  destination register of the head entry (low 5 bits of the DR array)
- head_value  in  32  value of the head entry
- st_commit_req  out  1  head store may write memory
- st_commit_ack  in  1  memory accepted the store
- flush  in  1  mispredict/exception flush of all entries
- commit  out  1  head retires this cycle (commit strobe to the ROB arrays)
- commit_ptr_rob_idx  out  IDX_W  current head index
- commit_ready  out  1  head is eligible to retire
- cir_q_empty  out  1  occupancy == 0
- cir_q_full  out  1  occupancy == DEPTH
- occupancy  out  IDX_W+1  live entry count
- rf_valid  out  1  regfile write valid (registered)
- rf_value  out  32  regfile write data
- rf_rob_idx  out  IDX_W  retiring ROB index
- rf_regfile_idx  out  5  destination register

Behaviour:
- State registers:
  - head, tail: IDX_W bits.
  - count: IDX_W+1 bits.
  - FSM: RUN, ST_WAIT.
- Reset: head=tail=0, count=0, state=RUN.
- Output values in reset: cir_q_empty=1, cir_q_full=0, all strobes 0, rf_* = 0.
- Pointer wrap: head and tail increment modulo DEPTH (31 -> 0). count is never derived from pointer difference.
- Issue:
  - issue_ack = issue_req & ~cir_q_full & ~flush & ~rst. The full check uses registered count only.
  - issue_rob_idx = tail.
  - On ack: tail advances and count increments.
- commit_ready = (state==RUN) & ~cir_q_empty & head_done.
- RUN state:
  - commit_ready & ~head_is_store: commit=1 combinationally the same cycle; head advances; count decrements.
  - commit_ready & head_is_store: st_commit_req=1 combinationally; no commit. Next state is ST_WAIT, unless st_commit_ack is already 1 that cycle, in which case the head commits immediately.
- ST_WAIT state:
  - st_commit_req held at 1.
  - On st_commit_ack: commit=1, head advances, return to RUN.
  - head_done is ignored while in ST_WAIT.
- Simultaneous issue and commit: count unchanged; both pointers advance.
  - Full plus commit in the same cycle: issue is still refused (registered full).
  - Empty plus issue: no commit, since the new entry is not yet visible at the head.
- Regfile bus, registered one cycle after commit:
  - rf_valid = commit & (head_dr != 0) & ~head_is_store.
  - rf_value, rf_rob_idx, rf_regfile_idx are captured from head_value, head, head_dr.
  - When no commit: rf_valid=0 and the other rf_* fields hold their last value.
  - Stores and x0 destinations retire with rf_valid=0.
- Flush:
  - Has priority over issue and commit that cycle: issue_ack=0, commit=0, st_commit_req=0.
  - Next cycle: head=tail=0, count=0, state=RUN, rf_valid=0.
  - Flush while in ST_WAIT abandons the store; the memory side must drop its request on flush.
- rst mid-operation behaves exactly as flush and also clears the rf_* fields.
- Invariants (assert in RTL and bench):
  - count <= DEPTH.
  - cir_q_empty == (count==0).
  - cir_q_full == (count==DEPTH).
  - commit never asserted while cir_q_empty.

Test Plan:
1. Reset, then 32 consecutive issue_req with head_done=0 -> issue_rob_idx 0..31, after 32 grants cir_q_full=1, occupancy=32; 33rd request gives issue_ack=0.
2. Issue 3 entries, set head_done=1, head_is_store=0, head_dr=5, head_value=0xDEADBEEF -> commit pulses at idx 0,1,2 on three consecutive cycles; rf_valid=1, rf_regfile_idx=5, rf_value=0xDEADBEEF, rf_rob_idx=0/1/2, each one cycle after its commit; cir_q_empty=1 at end.
3. Head store done, st_commit_ack delayed 4 cycles -> st_commit_req high for 5 cycles, commit once on the ack cycle, rf_valid stays 0.
4. Wrap-around: prefill to head=30, tail=30, then issue 4 and commit 4 -> tail sequence 30,31,0,1, head returns to 2, occupancy=0; during simultaneous issue+commit cycles occupancy is unchanged.
5. Flush with occupancy=12 while in ST_WAIT -> next cycle head=tail=0, occupancy=0, state RUN, st_commit_req=0, no commit; issue_ack=0 during the flush cycle.
6. Head with head_dr=0, done -> commit=1, rf_valid=0 on the following cycle; rst asserted with occupancy=7 -> cir_q_empty=1 and all rf_* = 0 next cycle.
